// File: rtl/fetch_stage.sv
// fetch_stage: program counter, imem handshake, skid buffer, stall/redirect handling
module fetch_stage #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     inst,
    output logic [PC_W-1:0] inst_pc,
    output logic            inst_valid
);
    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;
    state_t          r_state, w_next;
    logic [PC_W-1:0] r_pc, r_old_pc, r_skid_pc, r_inst_pc;
    logic [15:0]     r_skid, r_inst;
    logic            r_valid;
    logic            w_req;
    logic [PC_W-1:0] w_addr;
    // request decode and next state; HOLD doubles as the skid-buffer-full flag
    always_comb begin
        w_req  = r_state != HOLD;
        w_addr = r_state == DRAIN ? r_old_pc : r_pc;
        w_next = r_state;
        if (redirect) w_next = (w_req && !imem_ack) ? DRAIN : FETCH;
        else if (r_state == FETCH && imem_ack && stall) w_next = HOLD;
        else if (r_state == DRAIN && imem_ack) w_next = FETCH;
        else if (r_state == HOLD && !stall) w_next = FETCH;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FETCH;
        else r_state <= w_next;
    end
    // pc, skid buffer and instruction output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_old_pc  <= '0;
            r_skid    <= '0;
            r_skid_pc <= '0;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
        end else if (redirect) begin
            r_pc     <= redirect_pc;
            r_old_pc <= w_addr;
            r_inst   <= '0;
            r_valid  <= 1'b0;
        end else if (r_state == FETCH) begin
            if (imem_ack) begin
                r_pc <= r_pc + 1'b1;
                if (stall) begin
                    r_skid    <= imem_data;
                    r_skid_pc <= r_pc;
                end else begin
                    r_inst    <= imem_data;
                    r_inst_pc <= r_pc;
                    r_valid   <= 1'b1;
                end
            end else if (!stall) begin
                r_inst  <= '0;
                r_valid <= 1'b0;
            end
        end else if (r_state == DRAIN) begin
            if (!stall) begin
                r_inst  <= '0;
                r_valid <= 1'b0;
            end
        end else if (!stall) begin
            r_inst    <= r_skid;
            r_inst_pc <= r_skid_pc;
            r_valid   <= 1'b1;
        end
    end
    assign imem_req   = w_req;
    assign imem_addr  = w_addr;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_valid;
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the control/decode block; produces the 16-bit instruction word it decodes (opcode [15:12], register fields [11:0]).
- Owns the program counter and drives the instruction-memory request/acknowledge handshake.
- Applies stall and redirect (jump/taken branch), and emits the all-zero word as a bubble (decodes to all-zero control, i.e. NOP).

Parameters:
PC_W, 8, program-counter / instruction-memory address width (word addressed)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  PC_W  fetch address; stable while imem_req high
imem_ack  in  1  memory response valid; imem_data valid in the same cycle
imem_data  in  16  instruction word from memory
stall  in  1  downstream hold: keep inst/inst_pc/inst_valid unchanged
redirect  in  1  one-cycle pulse: jump or taken branch
redirect_pc  in  PC_W  new fetch target, sampled when redirect=1
inst  out  16  instruction to control/decode (16'h0000 = bubble)
inst_pc  out  PC_W  address of inst
inst_valid  out  1  inst holds a real fetched instruction

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All outputs are registered except imem_req/imem_addr, which are decoded from the FSM and address registers.
- Reset values: pc=RESET_PC, inst=16'h0000, inst_pc=0, inst_valid=0, skid buffer empty, FSM=FETCH. Reset asserted mid-transaction abandons it; the bench must ignore any late ack.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc.
  - DRAIN: imem_req=1, imem_addr=old pc; waits for ack of an abandoned request.
  - HOLD: imem_req=0; skid buffer full.
- Handshake:
  - Once raised, imem_req stays high with constant imem_addr until imem_ack. The ack may arrive in the first req cycle (zero-wait memory).
  - Ack completes the transfer; pc <= pc+1 modulo 2^PC_W (255 wraps to 0 at PC_W=8).
- Normal flow (FETCH, ack, no stall, no redirect): next edge inst<=imem_data, inst_pc<=pc, inst_valid<=1. Throughput is 1 instruction/cycle with zero-wait memory. Latency from req to inst is 1 edge after ack.
- No ack and no stall: inst<=16'h0000, inst_valid<=0 (bubble); inst_pc unchanged.
- Stall:
  - inst/inst_pc/inst_valid hold.
  - An ack arriving during stall is captured into a one-entry skid buffer (word+pc); FSM goes to HOLD.
  - When stall drops, the buffer drains to inst on that edge. FSM returns to FETCH in the same edge, so the request is re-raised the cycle after release.
  - Buffer contents take precedence over memory data; no request is issued while the buffer is full.
- Redirect (highest priority, overrides stall):
  - inst<=16'h0000, inst_valid<=0, skid buffer cleared, pc<=redirect_pc.
  - No request outstanding, or ack in the same cycle: ack data discarded, FSM=FETCH at redirect_pc next cycle.
  - Request outstanding without ack: FSM=DRAIN. Old address held until ack, data discarded, then FETCH at redirect_pc.
  - Redirect while in DRAIN: pending target replaced; remain in DRAIN.
- inst_valid=1 never accompanies inst=16'h0000 produced as a bubble. A fetched all-zero word is passed with inst_valid=1.

Test Plan:
- Reset, zero-wait memory returning mem[a]=16'h1000+a, no stall -> imem_addr 0,1,2,... each cycle; inst 16'h1000,16'h1001,... one edge behind, inst_valid=1 continuous.
- Memory acks 2 cycles after req -> imem_addr held stable across wait cycles; inst shows 16'h0000/valid=0 bubbles between fetched words; pc advances only on ack.
- stall high for 3 cycles while ack arrives in the second -> inst frozen; after release the buffered word appears on the first edge; no duplicate or skipped address.
- redirect with redirect_pc=8'h40 while a request to 8'h05 is outstanding -> req stays at 8'h05 until ack, that word never appears on inst; next request at 8'h40; inst=16'h0000 with valid=0 in between.
- redirect and stall together with full skid buffer -> buffer discarded, inst=16'h0000, next fetch at redirect_pc.
- pc=8'hFF fetch with ack -> next imem_addr=8'h00; rst pulsed mid-wait -> outputs return to reset values immediately (asynchronously), fetch restarts at RESET_PC.
